// File: rtl/imm_encoder_if.sv
// Handshake bundle between an immediate producer and imm_encoder: request side
// (imm, format select, base word) and encoded-word response side.
interface imm_encoder_if #(
  parameter int INSTR_WIDTH = 32
);
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] imm;
  logic [1:0]             imm_src;
  logic [INSTR_WIDTH-1:0] base;
  logic                   out_valid;
  logic                   out_ready;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   out_err;

  modport master (
    output in_valid, imm, imm_src, base, out_ready,
    input  in_ready, out_valid, instr, out_err
  );

  modport slave (
    input  in_valid, imm, imm_src, base, out_ready,
    output in_ready, out_valid, instr, out_err
  );
endinterface

// File: rtl/imm_encoder.sv
// Scatters a signed immediate into an RV32I I/S/B/J word and flags range/alignment errors.
// Latency: 2 cycles (stage A pack register, stage B output register), 1 word/cycle.
// Backpressure: 2-entry elastic pipe, in_ready falls only when both stages are full.
// Optional IMM_ENC_ERRCNT_EN adds a saturating err_count of delivered error words.
module imm_encoder #(
  parameter int INSTR_WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  imm_encoder_if.slave bus
`ifdef IMM_ENC_ERRCNT_EN
  ,
  output logic [15:0]  err_count
`endif
);

  typedef struct packed {
    logic [INSTR_WIDTH-1:0] word;
    logic                   err;
  } enc_t;

  localparam logic [1:0] FMT_I = 2'b00;
  localparam logic [1:0] FMT_S = 2'b01;
  localparam logic [1:0] FMT_B = 2'b10;
  localparam logic [1:0] FMT_J = 2'b11;

  logic [INSTR_WIDTH-1:0] imm;
  enc_t                   enc;

  enc_t a_q, a_d;
  enc_t b_q, b_d;
  logic a_vld_q, a_vld_d;
  logic b_vld_q, b_vld_d;
  logic adv_b;
  logic in_hs;

  assign imm = bus.imm;

  // The range check is "sign-extending the truncated field gives back imm".
  always_comb begin
    enc.word = bus.base;
    enc.err  = 1'b0;
    case (bus.imm_src)
      FMT_I: begin
        enc.word[31:20] = imm[11:0];
        enc.err         = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_S: begin
        enc.word[31:25] = imm[11:5];
        enc.word[11:7]  = imm[4:0];
        enc.err         = (imm != {{20{imm[11]}}, imm[11:0]});
      end
      FMT_B: begin
        enc.word[31]    = imm[12];
        enc.word[30:25] = imm[10:5];
        enc.word[11:8]  = imm[4:1];
        enc.word[7]     = imm[11];
        enc.err         = (imm != {{19{imm[12]}}, imm[12:0]}) || imm[0];
      end
      default: begin
        enc.word[31]    = imm[20];
        enc.word[30:21] = imm[10:1];
        enc.word[20]    = imm[11];
        enc.word[19:12] = imm[19:12];
        enc.err         = (imm != {{11{imm[20]}}, imm[20:0]}) || imm[0];
      end
    endcase
  end

  assign adv_b        = !b_vld_q || bus.out_ready;
  assign bus.in_ready = !a_vld_q || adv_b;
  assign in_hs        = bus.in_valid && bus.in_ready;

  always_comb begin
    a_d     = a_q;
    a_vld_d = a_vld_q;
    b_d     = b_q;
    b_vld_d = b_vld_q;
    if (adv_b) begin
      b_vld_d = a_vld_q;
      if (a_vld_q) begin
        b_d = a_q;
      end
    end
    // A empties when B takes it, unless a new word lands in the same edge.
    if (in_hs) begin
      a_d     = enc;
      a_vld_d = 1'b1;
    end else if (adv_b) begin
      a_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      a_vld_q <= 1'b0;
      b_q     <= '0;
      b_vld_q <= 1'b0;
    end else begin
      a_q     <= a_d;
      a_vld_q <= a_vld_d;
      b_q     <= b_d;
      b_vld_q <= b_vld_d;
    end
  end

  assign bus.out_valid = b_vld_q;
  assign bus.instr     = b_q.word;
  assign bus.out_err   = b_q.err;

`ifdef IMM_ENC_ERRCNT_EN
  logic [15:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (b_vld_q && bus.out_ready && b_q.err && (err_cnt_q != 16'hFFFF)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt_q <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed vector table, backpressure/reset sequences and
// randomized traffic scored against an arithmetic reference model.
module tb_imm_encoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  imm_encoder_if #(.INSTR_WIDTH(32)) bus ();

`ifdef IMM_ENC_ERRCNT_EN
  logic [15:0] err_count;
`endif

  imm_encoder #(.INSTR_WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef IMM_ENC_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  src;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  exp_t exp_q[$];
  int   hs_cyc[$];
  logic prev_stall = 1'b0;
  exp_t prev_out;
  bit   rnd_on = 1'b0;
  vec_t vecs[$];

  task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, want, $time);
    end
  endtask

  // Reference: field placement by shift/mask, legality by signed integer range.
  function automatic exp_t model(input logic [31:0] imm, input logic [1:0] src,
                                 input logic [31:0] base);
    longint      v = longint'($signed(imm));
    longint      lo, hi;
    bit          even;
    logic [31:0] mask, field;
    exp_t        r;
    case (src)
      2'd0: begin
        lo = -2048; hi = 2047; even = 1'b0;
        mask  = 32'hFFF0_0000;
        field = (imm & 32'hFFF) << 20;
      end
      2'd1: begin
        lo = -2048; hi = 2047; even = 1'b0;
        mask  = 32'hFE00_0F80;
        field = (((imm >> 5) & 32'h7F) << 25) | ((imm & 32'h1F) << 7);
      end
      2'd2: begin
        lo = -4096; hi = 4094; even = 1'b1;
        mask  = 32'hFE00_0F80;
        field = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25)
              | (((imm >> 1) & 32'hF) << 8) | (((imm >> 11) & 32'h1) << 7);
      end
      default: begin
        lo = -1048576; hi = 1048574; even = 1'b1;
        mask  = 32'hFFFF_F000;
        field = (((imm >> 20) & 32'h1) << 31) | (((imm >> 1) & 32'h3FF) << 21)
              | (((imm >> 11) & 32'h1) << 20) | (((imm >> 12) & 32'hFF) << 12);
      end
    endcase
    r.instr = (base & ~mask) | field;
    r.err   = (v < lo) || (v > hi) || (even && (imm % 2 != 0));
    return r;
  endfunction

  function automatic vec_t mk(input logic [31:0] imm, input logic [1:0] src,
                              input logic [31:0] base, input logic [31:0] instr,
                              input logic err);
    vec_t v;
    v.imm = imm; v.src = src; v.base = base; v.instr = instr; v.err = err;
    return v;
  endfunction

  function automatic logic [31:0] rand_imm();
    int edges[16] = '{-2048, -2049, 2047, 2048, -4096, -4097, 4094, 4095,
                      4096, -1048576, -1048577, 1048574, 1048575, 1048576, 0, -1};
    int v;
    case ($urandom_range(0, 3))
      0:       v = int'($urandom);
      1:       v = edges[$urandom_range(0, 15)];
      2:       v = int'($urandom_range(0, 8191)) - 4096;
      default: v = int'($urandom_range(0, 4194303)) - 2097152;
    endcase
    return v;
  endfunction

  // Output scoreboard, stall-stability check and input capture, all at negedge.
  always @(negedge clk) begin
    exp_t e;
    cyc = cyc + 1;
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk1("stall_valid_held", bus.out_valid, 1'b1);
        chk32("stall_instr_held", bus.instr, prev_out.instr);
        chk1("stall_err_held", bus.out_err, prev_out.err);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_word: got %h, expected no word (t=%0t)", bus.instr, $time);
        end else begin
          e = exp_q.pop_front();
          chk32("sb_instr", bus.instr, e.instr);
          chk1("sb_err", bus.out_err, e.err);
          hs_cyc.push_back(cyc);
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(bus.imm, bus.imm_src, bus.base));
      end
      prev_stall     = bus.out_valid && !bus.out_ready;
      prev_out.instr = bus.instr;
      prev_out.err   = bus.out_err;
    end
  end

  // Entered just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [31:0] imm, input logic [1:0] src, input logic [31:0] base);
    int   g = 0;
    logic hs = 1'b0;
    bus.in_valid = 1'b1;
    bus.imm      = imm;
    bus.imm_src  = src;
    bus.base     = base;
    while (!hs && g < 200) begin
      @(negedge clk);
      hs = bus.in_ready;
      g++;
    end
    chk1("send_accepted", hs, 1'b1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int g = 0;
    while ((exp_q.size() != 0 || bus.out_valid) && g < 500) begin
      @(negedge clk);
      g++;
    end
    chk32("drain_empty", exp_q.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "timeout");
  end

  initial begin
    int base_hs;
    vecs.push_back(mk(32'hFFFF_FFFF, 2'b00, 32'h0000_0093, 32'hFFF0_0093, 1'b0));
    vecs.push_back(mk(32'd2048,      2'b00, 32'h0000_0093, 32'h8000_0093, 1'b1));
    vecs.push_back(mk(32'd5,         2'b00, 32'hFFFF_FFFF, 32'h005F_FFFF, 1'b0));
    vecs.push_back(mk(32'd8,         2'b01, 32'h0000_2023, 32'h0000_2423, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFF, 2'b01, 32'h0000_2023, 32'hFE00_2FA3, 1'b0));
    vecs.push_back(mk(32'hFFFF_FFFC, 2'b10, 32'h0000_0063, 32'hFE00_0EE3, 1'b0));
    vecs.push_back(mk(32'd3,         2'b10, 32'h0000_0063, 32'h0000_0163, 1'b1));
    vecs.push_back(mk(32'd2048,      2'b11, 32'h0000_006F, 32'h0010_006F, 1'b0));
    vecs.push_back(mk(32'hFFF0_0000, 2'b11, 32'h0000_006F, 32'h8000_006F, 1'b0));
    vecs.push_back(mk(32'd1,         2'b11, 32'h0000_006F, 32'h0000_006F, 1'b1));

    bus.in_valid  = 1'b0;
    bus.imm       = '0;
    bus.imm_src   = '0;
    bus.base      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk1("rst_out_valid", bus.out_valid, 1'b0);
    chk32("rst_instr", bus.instr, 32'h0);
    chk1("rst_out_err", bus.out_err, 1'b0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk1("rst_in_ready", bus.in_ready, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.imm      = vecs[i].imm;
      bus.imm_src  = vecs[i].src;
      bus.base     = vecs[i].base;
      @(posedge clk);
      #1 bus.in_valid = 1'b0;
      @(negedge clk);
      chk1($sformatf("vec%0d_not_yet", i), bus.out_valid, 1'b0);
      @(negedge clk);
      chk1($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
      chk32($sformatf("vec%0d_instr", i), bus.instr, vecs[i].instr);
      chk1($sformatf("vec%0d_err", i), bus.out_err, vecs[i].err);
    end
    drain();

    bus.out_ready = 1'b0;
    base_hs = hs_cyc.size();
    send(32'd1, 2'b00, 32'h0000_0013);
    send(32'd4096, 2'b00, 32'h0000_0013);
    @(negedge clk);
    chk1("bp_in_ready_low", bus.in_ready, 1'b0);
    fork
      send(32'd3, 2'b01, 32'h0000_2023);
      begin
        repeat (3) begin
          @(negedge clk);
          chk1("bp_in_ready_held_low", bus.in_ready, 1'b0);
        end
        @(posedge clk);
        #1 bus.out_ready = 1'b1;
      end
    join
    send(32'hFFFF_FFF8, 2'b10, 32'h0000_0063);
    drain();
    chk32("bp_word_count", hs_cyc.size() - base_hs, 32'd4);
    if (hs_cyc.size() >= base_hs + 4) begin
      for (int j = 1; j < 4; j++) begin
        chk32("bp_one_per_cycle", hs_cyc[base_hs+j] - hs_cyc[base_hs+j-1], 32'd1);
      end
    end

    bus.out_ready = 1'b0;
    send(32'd7, 2'b00, 32'h0000_0013);
    send(32'd9, 2'b00, 32'h0000_0013);
    @(negedge clk);
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1;
    chk1("midrst_out_valid", bus.out_valid, 1'b0);
    chk32("midrst_instr", bus.instr, 32'h0);
    chk1("midrst_out_err", bus.out_err, 1'b0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk1("midrst_no_stale", bus.out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

`ifdef IMM_ENC_ERRCNT_EN
    chk32("errcnt_reset", 32'(err_count), 32'd0);
    send(32'd2048, 2'b00, 32'h0000_0013);
    send(32'd5, 2'b10, 32'h0000_0063);
    send(32'd0, 2'b00, 32'h0000_0013);
    send(32'd2097152, 2'b11, 32'h0000_006F);
    drain();
    chk32("errcnt_three", 32'(err_count), 32'd3);
`endif

    rnd_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send(rand_imm(), 2'($urandom_range(0, 3)), $urandom);
        end
        rnd_on = 1'b0;
      end
      begin
        while (rnd_on) begin
          @(posedge clk);
          #1 bus.out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
